// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared types and constants for the volleyball match sequencer
//
// Purpose: state encoding, side encoding and score width used by
// match_controller and its testbench.
package match_pkg;

  localparam int SCORE_W = 4;

  // Side encoding used for serve_side, winner and the pending rally side.
  localparam logic SIDE_PL1 = 1'b0;
  localparam logic SIDE_PL2 = 1'b1;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT_PAUSE,
    GAME_OVER
  } state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - vsync edge detector plus shared frame counter
//
// Purpose: turns the vsync level into a one-cycle frame tick and counts
// ticks up to a programmable terminal value.
// Ports:
//   pclk, rst   pixel clock, synchronous active-high reset
//   vsync_in    raw vsync level from the timing chain
//   clr         force the counter back to zero
//   en          count ticks while high
//   terminal    last count value; count_done fires on the tick that hits it
//   tick        one-cycle pulse, one cycle after the vsync rising edge
//   count_done  tick & en & count == terminal
module frame_tick_gen #(
  parameter int CNT_W = 8
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync_in,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic             tick,
  output logic             count_done
);

  logic             vsync_q;
  logic             vsync_qq;
  logic [CNT_W-1:0] count;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
    end else begin
      vsync_q  <= vsync_in;
      vsync_qq <= vsync_q;
    end
  end

  assign tick       = vsync_q & ~vsync_qq;
  assign count_done = tick & en & (count == terminal);

  // Wraps to zero on the terminal tick so the next counted phase starts
  // clean without an explicit clear from the sequencer.
  always_ff @(posedge pclk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tick && en) begin
      count <= (count == terminal) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - volleyball match sequencer: scores, serve, freeze and round timing
//
// Purpose: converts ball-floor events into scores, serve ownership and
// round/pause timing; every visible change lands on a frame tick.
// Optional feature: define SERVE_RULE_EN for the side-out rule (only the
// serving side scores; a rally lost by the server only moves the serve).
// Ports:
//   pclk, rst            pixel clock, synchronous active-high reset
//   vsync_in             vsync level; its rising edge is the frame tick
//   start_btn            level, starts/restarts a match on a tick
//   ball_floor_l/_r      one-cycle floor pulses (left = point to player 2)
//   scorepl1, scorepl2   player scores
//   serve_side           0 = player 1 serves, 1 = player 2 serves
//   freeze               hold physics and players
//   round_reset          one-cycle reposition pulse for a serve
//   game_over, winner    match finished and who won
module match_controller
  import match_pkg::*;
#(
  parameter int WIN_SCORE    = 15,
  parameter int PAUSE_FRAMES = 60,
  parameter int SERVE_FRAMES = 30
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vsync_in,
  input  logic               start_btn,
  input  logic               ball_floor_l,
  input  logic               ball_floor_r,
  output logic [SCORE_W-1:0] scorepl1,
  output logic [SCORE_W-1:0] scorepl2,
  output logic               serve_side,
  output logic               freeze,
  output logic               round_reset,
  output logic               game_over,
  output logic               winner
);

  localparam int MAX_FR = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int CNT_W  = $clog2(MAX_FR) + 1;
  localparam logic [CNT_W-1:0] SERVE_TERM = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] PAUSE_TERM = CNT_W'(PAUSE_FRAMES - 1);
  localparam score_t WIN = score_t'(WIN_SCORE);

  state_t     state;
  logic       pending;
  logic       pend_side;
  logic       tick;
  logic       count_done;
  logic       start_go;
  logic       cnt_en;
  logic [CNT_W-1:0] terminal;
  score_t     won_score;

  assign start_go  = tick & start_btn & ((state == IDLE) || (state == GAME_OVER));
  assign cnt_en    = (state == SERVE) || (state == POINT_PAUSE);
  assign terminal  = (state == SERVE) ? SERVE_TERM : PAUSE_TERM;
  assign won_score = ((pend_side == SIDE_PL2) ? scorepl2 : scorepl1) + 1'b1;

  frame_tick_gen #(
    .CNT_W(CNT_W)
  ) u_frame_tick_gen (
    .pclk       (pclk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .clr        (start_go),
    .en         (cnt_en),
    .terminal   (terminal),
    .tick       (tick),
    .count_done (count_done)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      scorepl1    <= '0;
      scorepl2    <= '0;
      serve_side  <= SIDE_PL1;
      freeze      <= 1'b1;
      round_reset <= 1'b0;
      game_over   <= 1'b0;
      winner      <= SIDE_PL1;
      pending     <= 1'b0;
      pend_side   <= SIDE_PL1;
    end else begin
      round_reset <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start_go) begin
            scorepl1    <= '0;
            scorepl2    <= '0;
            serve_side  <= SIDE_PL1;
            game_over   <= 1'b0;
            winner      <= SIDE_PL1;
            freeze      <= 1'b1;
            round_reset <= 1'b1;
            state       <= SERVE;
          end
        end
        SERVE: begin
          if (count_done) begin
            freeze <= 1'b0;
            state  <= PLAY;
          end
        end
        PLAY: begin
          if (tick && pending) begin
            pending    <= 1'b0;
            freeze     <= 1'b1;
            serve_side <= pend_side;
            state      <= POINT_PAUSE;
`ifdef SERVE_RULE_EN
            // Side-out: a rally won by the receiver only transfers the serve.
            if (pend_side == serve_side) begin
`else
            begin
`endif
              if (pend_side == SIDE_PL2) scorepl2 <= won_score;
              else                       scorepl1 <= won_score;
              if (won_score == WIN) begin
                game_over <= 1'b1;
                winner    <= pend_side;
                state     <= GAME_OVER;
              end
            end
          end else if (!pending && (ball_floor_l || ball_floor_r)) begin
            // Left floor hit wins a simultaneous pair: point to player 2.
            pending   <= 1'b1;
            pend_side <= ball_floor_l ? SIDE_PL2 : SIDE_PL1;
          end
        end
        POINT_PAUSE: begin
          if (count_done) begin
            round_reset <= 1'b1;
            state       <= SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - self-checking bench for match_controller
module tb_match_controller;
  import match_pkg::*;

  localparam int FRAME = 10;
  localparam int WIN   = 15;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       start_btn;
  logic       ball_floor_l;
  logic       ball_floor_r;
  logic [3:0] scorepl1;
  logic [3:0] scorepl2;
  logic       serve_side;
  logic       freeze;
  logic       round_reset;
  logic       game_over;
  logic       winner;

  int   checks = 0;
  int   errors = 0;
  int   ph;
  logic vs_last = 1'b0;
  logic rise = 1'b0;

  typedef struct {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       side;
    logic       go;
    logic       win;
  } exp_t;

  typedef struct {
    logic l;
    logic r;
    logic dup;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[20];

  match_controller dut (
    .pclk         (pclk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .start_btn    (start_btn),
    .ball_floor_l (ball_floor_l),
    .ball_floor_r (ball_floor_r),
    .scorepl1     (scorepl1),
    .scorepl2     (scorepl2),
    .serve_side   (serve_side),
    .freeze       (freeze),
    .round_reset  (round_reset),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 pclk = ~pclk;

  initial begin
    vsync_in = 1'b0;
    ph = FRAME - 1;
    forever begin
      @(negedge pclk);
      ph = (ph == FRAME - 1) ? 0 : ph + 1;
      vsync_in = (ph < FRAME / 2);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    rise = vsync_in && !vs_last;
    vs_last = vsync_in;
    #1;
  endtask

  task automatic wait_rise(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!rise && n < 3 * FRAME);
    if (!rise) chk({name, "_rise_timeout"}, 0, 1);
  endtask

  task automatic wait_mid_frame();
    int n = 0;
    while (ph != 2 && n < 2 * FRAME) begin
      step();
      n++;
    end
  endtask

  task automatic wait_freeze_low(output int nrise);
    int n = 0;
    nrise = 0;
    while (freeze !== 1'b0 && n < 100 * FRAME) begin
      step();
      n++;
      if (rise) nrise++;
    end
    if (freeze !== 1'b0) chk("freeze_low_timeout", freeze, 0);
  endtask

  task automatic wait_round_reset(output int nrise);
    int n = 0;
    nrise = 0;
    while (round_reset !== 1'b1 && n < 100 * FRAME) begin
      step();
      n++;
      if (rise) nrise++;
    end
    if (round_reset !== 1'b1) chk("round_reset_timeout", round_reset, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s1"}, scorepl1, 0);
    chk({tag, "_s2"}, scorepl2, 0);
    chk({tag, "_serve"}, serve_side, 0);
    chk({tag, "_freeze"}, freeze, 1);
    chk({tag, "_rr"}, round_reset, 0);
    chk({tag, "_go"}, game_over, 0);
    chk({tag, "_win"}, winner, 0);
  endtask

  task automatic start_match(input string tag);
    int n;
    start_btn = 1'b1;
    wait_rise(tag);
    step();
    start_btn = 1'b0;
    chk({tag, "_rr_pulse"}, round_reset, 1);
    chk({tag, "_s1"}, scorepl1, 0);
    chk({tag, "_s2"}, scorepl2, 0);
    chk({tag, "_go"}, game_over, 0);
    chk({tag, "_freeze"}, freeze, 1);
    step();
    chk({tag, "_rr_single"}, round_reset, 0);
    wait_freeze_low(n);
    chk({tag, "_serve_ticks"}, n, 30);
  endtask

  // Reference point rule: rally-point by default, side-out when enabled.
  function automatic exp_t model(input exp_t p, input logic l, input logic r);
    exp_t e;
    logic side;
    e = p;
    side = l ? 1'b1 : 1'b0;
    if (!l && !r) return e;
`ifdef SERVE_RULE_EN
    if (side != p.side) begin
      e.side = side;
      return e;
    end
`endif
    e.side = side;
    if (side) e.s2 = e.s2 + 1;
    else      e.s1 = e.s1 + 1;
    if ((side ? e.s2 : e.s1) == WIN) begin
      e.go  = 1'b1;
      e.win = side;
    end
    return e;
  endfunction

  task automatic rally(input int idx, input vec_t v, input exp_t prev);
    exp_t got;
    int   n;
    string tag;
    tag = $sformatf("rally%0d", idx);
    wait_mid_frame();
    ball_floor_l = v.l;
    ball_floor_r = v.r;
    step();
    ball_floor_l = 1'b0;
    ball_floor_r = 1'b0;
    if (v.dup) begin
      step();
      ball_floor_r = 1'b1;
      step();
      ball_floor_r = 1'b0;
    end
    sb.push_back(v.e);
    wait_rise(tag);
    chk({tag, "_s1_early"}, scorepl1, prev.s1);
    chk({tag, "_s2_early"}, scorepl2, prev.s2);
    step();
    got = sb.pop_front();
    chk({tag, "_s1"}, scorepl1, got.s1);
    chk({tag, "_s2"}, scorepl2, got.s2);
    chk({tag, "_serve"}, serve_side, got.side);
    chk({tag, "_go"}, game_over, got.go);
    chk({tag, "_winner"}, winner, got.win);
    chk({tag, "_freeze"}, freeze, 1);
    if (!got.go) begin
      wait_round_reset(n);
      chk({tag, "_pause_ticks"}, n, 60);
      step();
      chk({tag, "_rr_single"}, round_reset, 0);
      wait_freeze_low(n);
      chk({tag, "_serve_ticks"}, n, 30);
    end
  endtask

  initial begin
    exp_t cur;
    exp_t prev;
    int   last;
    int   rr_seen;

    rst = 1'b1;
    start_btn = 1'b0;
    ball_floor_l = 1'b0;
    ball_floor_r = 1'b0;

    // Rally table: r, then a simultaneous l+r with a trailing r, then l's.
    cur = '{s1: 4'd0, s2: 4'd0, side: 1'b0, go: 1'b0, win: 1'b0};
    last = 19;
    for (int i = 0; i < 20; i++) begin
      tbl[i].l   = (i != 0);
      tbl[i].r   = (i <= 1);
      tbl[i].dup = (i == 1);
      cur = model(cur, tbl[i].l, tbl[i].r);
      tbl[i].e = cur;
      if (cur.go && last == 19) last = i;
    end

    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2 * FRAME) step();
    check_reset_vals("idle");

    start_match("start1");

    prev = '{s1: 4'd0, s2: 4'd0, side: 1'b0, go: 1'b0, win: 1'b0};
    for (int i = 0; i <= last; i++) begin
      rally(i, tbl[i], prev);
      prev = tbl[i].e;
    end
    chk("final_s2", scorepl2, WIN);

    // Pulses after the match ends must change nothing.
    wait_mid_frame();
    ball_floor_l = 1'b1;
    step();
    ball_floor_l = 1'b0;
    step();
    ball_floor_r = 1'b1;
    step();
    ball_floor_r = 1'b0;
    repeat (3 * FRAME) step();
    chk("go_hold_s1", scorepl1, prev.s1);
    chk("go_hold_s2", scorepl2, prev.s2);
    chk("go_hold_go", game_over, 1);
    chk("go_hold_winner", winner, 1);
    chk("go_hold_freeze", freeze, 1);

    start_match("restart");

    // Reset with a point pending in PLAY.
    wait_mid_frame();
    ball_floor_r = 1'b1;
    step();
    ball_floor_r = 1'b0;
    rst = 1'b1;
    step();
    check_reset_vals("rst_pending");
    rst = 1'b0;
    rr_seen = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (round_reset === 1'b1) rr_seen++;
    end
    chk("rst_pending_no_rr", rr_seen, 0);
    check_reset_vals("rst_pending_idle");

    // Reset in the middle of a point pause.
    start_match("start3");
    wait_mid_frame();
    ball_floor_r = 1'b1;
    step();
    ball_floor_r = 1'b0;
    wait_rise("pause_apply");
    step();
    chk("pause_s1", scorepl1, 1);
    for (int i = 0; i < 20; i++) wait_rise("pause_run");
    rst = 1'b1;
    step();
    check_reset_vals("rst_pause");
    rst = 1'b0;
    rr_seen = 0;
    for (int i = 0; i < 70 * FRAME; i++) begin
      step();
      if (round_reset === 1'b1) rr_seen++;
    end
    chk("rst_pause_no_rr", rr_seen, 0);
    check_reset_vals("rst_pause_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
